// File: rtl/layer_loader_pkg.sv
// Shared definitions for the layer parameter loader: fixed-point word width,
// FSM state type and counter sizing helper.
package layer_loader_pkg;

    localparam int unsigned FP_N = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StDone
    } ld_state_e;

    // Bits needed to count 0..range-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned range);
        return (range <= 2) ? 1 : $clog2(range);
    endfunction

endpackage

// File: rtl/layer_loader.sv
// Streams end marker, bias and weights from a valid/ready source onto a layer's
// shared parameter bus, one node at a time, with a registered one-hot write enable.
module layer_loader
    import layer_loader_pkg::*;
#(
    parameter int unsigned sx = 99,
    parameter int unsigned sl = 99,
    parameter int unsigned n  = FP_N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          src_valid,
    input  logic [n-1:0]  src_data,
    output logic          src_ready,
    output logic [sl-1:0] we,
    output logic [n-1:0]  bus,
    output logic          busy,
    output logic          done
);

    localparam int unsigned WPN = sx + 2;
    localparam int unsigned WW  = cnt_width(WPN);
    localparam int unsigned NW  = cnt_width(sl);
    localparam logic [WW-1:0] WLAST = WW'(WPN - 1);
    localparam logic [NW-1:0] NLAST = NW'(sl - 1);

    ld_state_e     state;
    logic [WW-1:0] wcnt;
    logic [NW-1:0] ncnt;
    logic [sl-1:0] we_sel;
    logic          xfer;

    // src_ready is only ever high in LOAD, so no state qualifier is needed.
    assign xfer = src_valid && src_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            wcnt      <= '0;
            ncnt      <= '0;
            src_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StLoad;
                        wcnt      <= '0;
                        ncnt      <= '0;
                        src_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StLoad: begin
                    if (xfer) begin
                        if (wcnt == WLAST) begin
                            wcnt <= '0;
                            if (ncnt == NLAST) begin
                                ncnt      <= '0;
                                state     <= StFlush;
                                src_ready <= 1'b0;
                            end else begin
                                ncnt <= ncnt + 1'b1;
                            end
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    state <= StDone;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Node k owns we[sl-1-k], so node 0 is the MSB.
    always_comb begin
        we_sel = '0;
        for (int k = 0; k < int'(sl); k++) begin
            if (k == int'(sl) - 1 - int'(ncnt)) begin
                we_sel[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we  <= '0;
            bus <= '0;
        end else if (xfer) begin
            we  <= we_sel;
            bus <= src_data;
        end else begin
            we <= '0;
        end
    end

endmodule

// File: tb/tb_layer_loader.sv
// Scoreboard bench for layer_loader: driver pushes expected (we, bus) per accepted
// word from a word-index model; a negedge monitor pops and compares.
module tb_layer_loader;

    localparam int N     = 16;
    localparam int SX    = 3;
    localparam int SL    = 2;
    localparam int WPN   = SX + 2;
    localparam int TOTAL = SL * WPN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          src_valid = 1'b0;
    logic [N-1:0]  src_data = '0;
    logic          src_ready;
    logic [SL-1:0] we;
    logic [N-1:0]  bus;
    logic          busy;
    logic          done;

    logic          e_start = 1'b0;
    logic          e_valid = 1'b0;
    logic [N-1:0]  e_data = '0;
    logic          e_ready;
    logic [0:0]    e_we;
    logic [N-1:0]  e_bus;
    logic          e_busy;
    logic          e_done;

    always #5 clk = ~clk;

    layer_loader #(.sx(SX), .sl(SL), .n(N)) dut (
        .clk(clk), .rst(rst), .start(start), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .we(we), .bus(bus), .busy(busy), .done(done)
    );

    layer_loader #(.sx(1), .sl(1), .n(N)) dut_edge (
        .clk(clk), .rst(rst), .start(e_start), .src_valid(e_valid), .src_data(e_data),
        .src_ready(e_ready), .we(e_we), .bus(e_bus), .busy(e_busy), .done(e_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [SL-1:0] we;
        logic [N-1:0]  data;
        bit            last;
    } exp_t;

    exp_t         expq[$];
    logic [N-1:0] words[$];
    int           nacc = 0;
    int           m_idx = 0;
    int           loads_done = 0;
    int           done_seen = 0;
    logic         cur_v = 1'b0;
    logic         cur_rdy = 1'b0;
    logic         cur_rst = 1'b1;

    // Reference: word i of a load goes to node i / WPN, whose enable bit is SL-1-node.
    task automatic model_push(input logic [N-1:0] d);
        exp_t e;
        e.we   = '0;
        e.we[SL - 1 - m_idx / WPN] = 1'b1;
        e.data = d;
        e.last = (m_idx == TOTAL - 1);
        expq.push_back(e);
        if (e.last) begin
            m_idx = 0;
            loads_done++;
        end else begin
            m_idx++;
        end
    endtask

    task automatic step(input logic v, input logic s, input logic r);
        @(posedge clk);
        if (cur_rst) begin
            m_idx = 0;
        end else if (cur_v && cur_rdy) begin
            model_push(src_data);
            nacc++;
        end
        #1;
        src_valid = v;
        src_data  = (nacc < words.size()) ? words[nacc] : '0;
        start     = s;
        rst       = r;
        cur_v     = v;
        cur_rdy   = src_ready;
        cur_rst   = r;
    endtask

    bit due = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        bit   pop_last;
        pop_last = 1'b0;
        chk("we_onehot0", 64'($onehot0(we)), 64'd1);
        if (we != '0) begin
            if (expq.size() == 0) begin
                chk("unexpected_we", 64'(we), 64'd0);
            end else begin
                e = expq.pop_front();
                chk("we", 64'(we), 64'(e.we));
                chk("bus", 64'(bus), 64'(e.data));
                pop_last = e.last;
            end
        end
        if (done || due) chk("done_timing", 64'(done), 64'(due));
        if (done) done_seen++;
        due = pop_last;
    end

    // mode 0: valid always high; 1: alternating; 2: random.
    task automatic do_load(input int mode, input int start_at, input int rst_at,
                           input bit rnd_data, input bit start_in_done);
        int   cyc;
        logic v;
        words.delete();
        for (int i = 0; i < TOTAL; i++) begin
            words.push_back(rnd_data ? N'($urandom) : N'(i + 1));
        end
        nacc = 0;
        step(1'b0, 1'b1, 1'b0);
        cyc = 0;
        while (nacc < TOTAL && cyc < 200) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (rst_at >= 0 && nacc == rst_at) begin
                step(1'b1, 1'b0, 1'b1);
                step(1'b1, 1'b0, 1'b1);
                chk("rst_we", 64'(we), 64'd0);
                chk("rst_bus", 64'(bus), 64'd0);
                chk("rst_ready", 64'(src_ready), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                step(1'b0, 1'b0, 1'b0);
                return;
            end
            step(v, (start_at >= 0 && nacc == start_at), 1'b0);
            if (cyc == 0) begin
                chk("load_ready", 64'(src_ready), 64'd1);
                chk("load_busy", 64'(busy), 64'd1);
            end
            cyc++;
        end
        if (nacc < TOTAL) chk("load_timeout", 64'(nacc), 64'(TOTAL));
        chk("flush_busy", 64'(busy), 64'd1);
        chk("flush_ready", 64'(src_ready), 64'd0);
        step(1'b0, start_in_done, 1'b0);
        chk("done_busy", 64'(busy), 64'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("idle_ready", 64'(src_ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [N-1:0] ew[3];
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("reset_we", 64'(we), 64'd0);
        chk("reset_bus", 64'(bus), 64'd0);
        chk("reset_ready", 64'(src_ready), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        step(1'b0, 1'b0, 1'b0);

        do_load(0, -1, -1, 1'b0, 1'b1);
        do_load(1, -1, -1, 1'b0, 1'b0);
        do_load(0, 4, -1, 1'b0, 1'b0);
        do_load(0, -1, 7, 1'b0, 1'b0);
        do_load(0, -1, -1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) do_load(2, -1, -1, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) ew[k] = N'($urandom);
        e_start = 1'b1;
        @(posedge clk);
        #1;
        e_start = 1'b0;
        e_valid = 1'b1;
        e_data  = ew[0];
        chk("edge_ready", 64'(e_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (k < 2) e_data = ew[k + 1];
            else e_valid = 1'b0;
            chk("edge_we", 64'(e_we), 64'd1);
            chk("edge_bus", 64'(e_bus), 64'(ew[k]));
        end
        chk("edge_flush_done", 64'(e_done), 64'd0);
        @(posedge clk);
        #1;
        chk("edge_done", 64'(e_done), 64'd1);
        chk("edge_done_we", 64'(e_we), 64'd0);
        @(posedge clk);
        #1;
        chk("edge_done_once", 64'(e_done), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(expq.size()), 64'd0);
        chk("done_count", 64'(done_seen), 64'(loads_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
